// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared FSM state type and branch-forwarding select encodings
package pipe_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } mdu_state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Wide enough for MDU_LATENCY up to 31
  localparam int MDU_CNT_W = 5;

endpackage

// File: rtl/mdu_seq_fsm.sv
// rtl/mdu_seq_fsm.sv - multiply/divide sequencer: holds the front pipeline for MDU_LATENCY-1 cycles
module mdu_seq_fsm
  import pipe_pkg::*;
#(
  parameter int MDU_LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  output logic o_busy
);

  localparam logic [MDU_CNT_W-1:0] CNT_LOAD = MDU_CNT_W'(MDU_LATENCY - 1);
  localparam logic [MDU_CNT_W-1:0] CNT_LAST = MDU_CNT_W'(1);

  mdu_state_t           r_state;
  mdu_state_t           w_state_nxt;
  logic [MDU_CNT_W-1:0] r_mdu_cnt;
  logic [MDU_CNT_W-1:0] w_mdu_cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= RUN;
      r_mdu_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mdu_cnt <= w_mdu_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_mdu_cnt_nxt = r_mdu_cnt;
    case (r_state)
      RUN: begin
        if (i_start) begin
          w_state_nxt   = MDU_WAIT;
          w_mdu_cnt_nxt = CNT_LOAD;
        end
      end
      MDU_WAIT: begin
        if (r_mdu_cnt == CNT_LAST) begin
          w_state_nxt   = RUN;
          w_mdu_cnt_nxt = '0;
        end else begin
          w_mdu_cnt_nxt = r_mdu_cnt - CNT_LAST;
        end
      end
    endcase
  end

  assign o_busy = (r_state == MDU_WAIT);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/forward control for the 5-stage pipeline
// Optional stall-cycle perf counter built only with PIPE_STALL_PERF_EN defined.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_LATENCY = 4,
  parameter int REG_AW      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_branch,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_mdu_start,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] mem_dest,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_flush,
  output logic              ex_en,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mdu_busy,
  output logic [15:0]       stall_cycles
);

  logic w_ex_match;
  logic w_mem_match;
  logic w_data_stall;
  logic w_mdu_busy;

  // $0 is hardwired, so it never creates a dependency
  assign w_ex_match  = (ex_dest != '0) &&
                       ((id_uses_rs && (id_rs == ex_dest)) || (id_uses_rt && (id_rt == ex_dest)));
  assign w_mem_match = (mem_dest != '0) &&
                       ((id_uses_rs && (id_rs == mem_dest)) || (id_uses_rt && (id_rt == mem_dest)));

  assign w_data_stall = (ex_mem_read && w_ex_match) ||
                        (id_is_branch && ex_reg_write && w_ex_match) ||
                        (id_is_branch && mem_mem_read && w_mem_match);

  mdu_seq_fsm #(
    .MDU_LATENCY(MDU_LATENCY)
  ) u_mdu_seq (
    .clk    (clk),
    .reset  (reset),
    .i_start(ex_mdu_start),
    .o_busy (w_mdu_busy)
  );

  assign mdu_busy = w_mdu_busy;

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b1;
    id_ex_flush = 1'b0;
    ex_en       = 1'b1;
    if (!reset) begin
      if (w_mdu_busy) begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
        id_ex_en = 1'b0;
        ex_en    = 1'b0;
      end else if (w_data_stall) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end else if (branch_taken || jump) begin
        if_id_flush = 1'b1;
      end
    end
  end

  // A load in EX cannot forward; its data only exists from MEM/WB onward
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!reset) begin
      if (id_rs != '0) begin
        if (ex_reg_write && !ex_mem_read && (ex_dest == id_rs)) fwd_a = FWD_EXMEM;
        else if (mem_reg_write && (mem_dest == id_rs))          fwd_a = FWD_MEMWB;
      end
      if (id_rt != '0) begin
        if (ex_reg_write && !ex_mem_read && (ex_dest == id_rt)) fwd_b = FWD_EXMEM;
        else if (mem_reg_write && (mem_dest == id_rt))          fwd_b = FWD_MEMWB;
      end
    end
  end

`ifdef PIPE_STALL_PERF_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (!pc_en && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed vectors checked against a behavioural hazard model
module tb_pipe_hazard_ctrl;

  localparam int LAT = 4;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_dest, mem_dest;
  logic        id_uses_rs, id_uses_rt, id_is_branch, branch_taken, jump;
  logic        ex_reg_write, ex_mem_read, ex_mdu_start, mem_reg_write, mem_mem_read;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_en, mdu_busy;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cycles;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_en;
    logic       id_ex_flush;
    logic       ex_en;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       mdu_busy;
  } exp_t;

  int m_wait  = 0;
  int m_stall = 0;

  pipe_hazard_ctrl #(.MDU_LATENCY(LAT), .REG_AW(5)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .branch_taken(branch_taken), .jump(jump),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
    .ex_mdu_start(ex_mdu_start), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_dest(mem_dest), .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_en(ex_en), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic hz_on(input logic used, input logic [4:0] r);
    if (!used || r == 5'd0) return 1'b0;
    if (ex_mem_read && ex_dest == r) return 1'b1;
    if (id_is_branch && ex_reg_write && ex_dest == r) return 1'b1;
    if (id_is_branch && mem_mem_read && mem_dest == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] fwd_of(input logic [4:0] r);
    if (r == 5'd0) return 2'b00;
    if (ex_reg_write && !ex_mem_read && ex_dest == r) return 2'b01;
    if (mem_reg_write && mem_dest == r) return 2'b10;
    return 2'b00;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0};
    if (reset) return e;
    e.fwd_a = fwd_of(id_rs);
    e.fwd_b = fwd_of(id_rt);
    if (m_wait > 0) begin
      e.pc_en = 1'b0; e.if_id_en = 1'b0; e.id_ex_en = 1'b0; e.ex_en = 1'b0; e.mdu_busy = 1'b1;
    end else if (hz_on(id_uses_rs, id_rs) || hz_on(id_uses_rt, id_rt)) begin
      e.pc_en = 1'b0; e.if_id_en = 1'b0; e.id_ex_flush = 1'b1;
    end else if (branch_taken || jump) begin
      e.if_id_flush = 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_wait  <= 0;
      m_stall <= 0;
    end else begin
      if (!model_out().pc_en && m_stall < 65535) m_stall <= m_stall + 1;
      if (m_wait > 0) m_wait <= m_wait - 1;
      else if (ex_mdu_start) m_wait <= LAT - 1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    e = model_out();
    check("pc_en", pc_en, e.pc_en);
    check("if_id_en", if_id_en, e.if_id_en);
    check("if_id_flush", if_id_flush, e.if_id_flush);
    check("id_ex_en", id_ex_en, e.id_ex_en);
    check("id_ex_flush", id_ex_flush, e.id_ex_flush);
    check("ex_en", ex_en, e.ex_en);
    check("fwd_a", fwd_a, e.fwd_a);
    check("fwd_b", fwd_b, e.fwd_b);
    check("mdu_busy", mdu_busy, e.mdu_busy);
`ifdef PIPE_STALL_PERF_EN
    check("stall_cycles", stall_cycles, m_stall);
`else
    check("stall_cycles", stall_cycles, 0);
`endif
  end

  task automatic clr();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; id_is_branch = 0;
    branch_taken = 0; jump = 0; ex_reg_write = 0; ex_mem_read = 0; ex_dest = 0;
    ex_mdu_start = 0; mem_reg_write = 0; mem_mem_read = 0; mem_dest = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    ex_mem_read = 1; ex_reg_write = 1; ex_dest = 5; id_uses_rs = 1; id_rs = 5; branch_taken = 1;
    #3;
    check("lit rst pc_en", pc_en, 1);
    check("lit rst if_id_flush", if_id_flush, 0);
    check("lit rst id_ex_flush", id_ex_flush, 0);
    check("lit rst fwd_a", fwd_a, 0);
    repeat (2) @(posedge clk);
    #1;
    clr();
    reset = 1'b0;

    // load-use: lw $5 in EX, add reads $5
    cyc(); clr(); ex_mem_read = 1; ex_reg_write = 1; ex_dest = 5; id_uses_rs = 1; id_rs = 5;
    #2;
    check("lit lu pc_en", pc_en, 0);
    check("lit lu if_id_en", if_id_en, 0);
    check("lit lu id_ex_flush", id_ex_flush, 1);
    cyc(); clr(); mem_reg_write = 1; mem_mem_read = 1; mem_dest = 5; id_uses_rs = 1; id_rs = 5;
    #2;
    check("lit lu next pc_en", pc_en, 1);
    check("lit lu next fwd_a", fwd_a, 2'b10);
    cyc(); clr();
    #2;
    check("lit idle fwd_a", fwd_a, 2'b00);

    // beq rs=3 with add $3 in EX, then in MEM
    cyc(); clr(); id_is_branch = 1; id_uses_rs = 1; id_uses_rt = 1; id_rs = 3; id_rt = 4;
    ex_reg_write = 1; ex_dest = 3;
    #2;
    check("lit brex pc_en", pc_en, 0);
    check("lit brex fwd_a", fwd_a, 2'b01);
    cyc(); ex_reg_write = 0; ex_dest = 0; mem_reg_write = 1; mem_dest = 3;
    #2;
    check("lit brmem pc_en", pc_en, 1);
    check("lit brmem fwd_a", fwd_a, 2'b10);
    check("lit brmem fwd_b", fwd_b, 2'b00);
    cyc(); clr(); id_is_branch = 1; id_uses_rs = 1; id_rs = 3; ex_reg_write = 1; ex_dest = 0;
    #2;
    check("lit dest0 pc_en", pc_en, 1);
    check("lit dest0 fwd_a", fwd_a, 2'b00);

    // branch vs load in MEM; load targeting $0
    cyc(); clr(); id_is_branch = 1; id_uses_rt = 1; id_rt = 7; mem_mem_read = 1;
    mem_reg_write = 1; mem_dest = 7;
    #2;
    check("lit brmemld pc_en", pc_en, 0);
    check("lit brmemld fwd_b", fwd_b, 2'b10);
    cyc(); clr(); ex_mem_read = 1; ex_reg_write = 1; ex_dest = 0; id_uses_rs = 1; id_rs = 0;
    #2;
    check("lit r0 pc_en", pc_en, 1);

    // MDU sequence, redirect during wait is masked
    cyc(); clr(); ex_mdu_start = 1;
    #2;
    check("lit mdu start busy", mdu_busy, 0);
    check("lit mdu start pc_en", pc_en, 1);
    for (int i = 0; i < LAT - 1; i++) begin
      cyc(); clr();
      if (i == 1) branch_taken = 1;
      #2;
      check("lit mdu wait busy", mdu_busy, 1);
      check("lit mdu wait pc_en", pc_en, 0);
      check("lit mdu wait ex_en", ex_en, 0);
      check("lit mdu wait flush", if_id_flush, 0);
    end
    cyc(); clr();
    #2;
    check("lit mdu done busy", mdu_busy, 0);
    check("lit mdu done pc_en", pc_en, 1);

    // redirect, then redirect masked by load-use
    cyc(); clr(); branch_taken = 1;
    #2;
    check("lit redir flush", if_id_flush, 1);
    check("lit redir pc_en", pc_en, 1);
    cyc(); clr(); branch_taken = 1; ex_mem_read = 1; ex_dest = 9; id_uses_rt = 1; id_rt = 9;
    #2;
    check("lit redir lu flush", if_id_flush, 0);
    cyc(); ex_mem_read = 0; ex_dest = 0;
    #2;
    check("lit redir after flush", if_id_flush, 1);
    cyc(); clr(); jump = 1;
    #2;
    check("lit jump flush", if_id_flush, 1);

    // MDU start coinciding with a data stall
    cyc(); clr(); ex_mdu_start = 1; ex_mem_read = 1; ex_dest = 2; id_uses_rs = 1; id_rs = 2;
    #2;
    check("lit start+stall bubble", id_ex_flush, 1);
    check("lit start+stall busy", mdu_busy, 0);
    cyc(); clr();
    #2;
    check("lit start+stall next busy", mdu_busy, 1);
    check("lit start+stall next flush", id_ex_flush, 0);
    cyc(); cyc(); cyc();
    #2;
    check("lit start+stall done", mdu_busy, 0);

    // async reset in the middle of MDU_WAIT
    cyc(); clr(); ex_mdu_start = 1;
    cyc(); clr();
    cyc();
    #1;
    check("lit pre-reset busy", mdu_busy, 1);
    reset = 1'b1;
    #1;
    check("lit mid-reset busy", mdu_busy, 0);
    check("lit mid-reset pc_en", pc_en, 1);
    check("lit mid-reset ex_en", ex_en, 1);
    cyc(); reset = 1'b0;
    cyc();
    #2;
    check("lit post-reset busy", mdu_busy, 0);

`ifdef PIPE_STALL_PERF_EN
    cyc(); clr(); ex_mem_read = 1; ex_dest = 6; id_uses_rs = 1; id_rs = 6;
    repeat (70000) cyc();
    #2;
    check("lit perf saturate", stall_cycles, 16'hFFFF);
`else
    #2;
    check("lit perf disabled", stall_cycles, 0);
`endif

    cyc(); clr();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
